// File: rtl/mod_mul_stage.sv
// ---------------------------------------------------------------------------
// mod_mul_stage
//
// Two-stage valid/ready pipeline that forms the full 32-bit unsigned product
// of two 16-bit operands and passes it, with the zero-extended modulus, to a
// downstream Barrett reduction stage.
//
//   Stage 1 registers the operand pair and its modulus.
//   Stage 2 registers the 32-bit product and the modulus. The outputs come
//   only from stage 2.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   clear_i      synchronous flush of both stages, the counter and the flag
//   valid_i      upstream operand pair valid
//   ready_o      the block can accept an operand pair this cycle
//   in_1, in_2   operands a and b (16 bit)
//   q_i          modulus that goes with the pair (16 bit)
//   valid_o      product pair valid toward the reduction stage
//   ready_i      the reduction stage accepts this cycle
//   out_1        a*b, full 32-bit unsigned product
//   out_2        modulus, zero-extended to 32 bit
//   range_err_o  sticky: an accepted operand was >= its modulus
//   op_cnt_o     number of products delivered downstream (wraps)
// ---------------------------------------------------------------------------
module mod_mul_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [15:0] in_1,
  input  logic [15:0] in_2,
  input  logic [15:0] q_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] out_1,
  output logic [31:0] out_2,
  output logic        range_err_o,
  output logic [15:0] op_cnt_o
);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
  } s1_data_t;

  typedef struct packed {
    logic [31:0] prod;
    logic [15:0] q;
  } s2_data_t;

  // Pipeline state
  logic     s1_v;
  logic     s2_v;
  s1_data_t s1_d;
  s2_data_t s2_d;

  logic [15:0] op_cnt;
  logic        range_err;

  // Handshake terms
  logic s2_load;   // stage 2 is empty or is being drained this cycle
  logic s1_adv;    // stage 1 content moves into stage 2
  logic in_xfer;   // operand pair accepted on this edge
  logic out_xfer;  // product pair delivered on this edge
  logic in_bad;    // accepted operand is not below its modulus

  assign s2_load  = !s2_v || ready_i;
  assign s1_adv   = s1_v && s2_load;

  // Stage 1 can take a new pair when it is empty or its content moves on
  // this cycle; that reduces to the expression below, which also keeps
  // ready_o high while in reset because s1_v is held at zero.
  assign ready_o  = !s1_v || !s2_v || ready_i;

  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = s2_v && ready_i;

  // A zero modulus makes every operand out of range.
  assign in_bad   = (in_1 >= q_i) || (in_2 >= q_i);

  // -------------------------------------------------------------------------
  // Control state: valid bits, delivery counter, sticky range flag.
  // clear_i wins over every transfer in the same cycle.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, which is what makes the
  // stage-to-stage shift in a single edge correct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      op_cnt    <= 16'd0;
      range_err <= 1'b0;
    end else if (clear_i) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      op_cnt    <= 16'd0;
      range_err <= 1'b0;
    end else begin
      // Stage 2 takes whatever stage 1 holds (possibly a bubble) whenever
      // it is free to load.
      if (s2_load) begin
        s2_v <= s1_v;
      end
      // Stage 1 refills (or empties) whenever it can accept.
      if (ready_o) begin
        s1_v <= valid_i;
      end
      if (out_xfer) begin
        op_cnt <= op_cnt + 16'd1;
      end
      if (in_xfer && in_bad) begin
        range_err <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data path. Qualified by the valid bits above, so the payload registers
  // carry no reset.
  // -------------------------------------------------------------------------
  // NOTE: payload registers are deliberately left out of reset; nothing
  // downstream looks at them while the matching valid bit is low, and
  // leaving them unreset keeps the reset net off the wide data flops.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_d.a <= in_1;
      s1_d.b <= in_2;
      s1_d.q <= q_i;
    end
    if (s1_adv) begin
      // Widen both operands first so the multiply is evaluated at 32 bits.
      s2_d.prod <= {16'd0, s1_d.a} * {16'd0, s1_d.b};
      s2_d.q    <= s1_d.q;
    end
  end

  // Outputs come straight from stage-2 and control registers.
  assign valid_o     = s2_v;
  assign out_1       = s2_d.prod;
  assign out_2       = {16'd0, s2_d.q};
  assign op_cnt_o    = op_cnt;
  assign range_err_o = range_err;

endmodule

// File: tb/tb_mod_mul_stage.sv
// ---------------------------------------------------------------------------
// tb_mod_mul_stage
//
// Directed self-checking bench for mod_mul_stage. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point, well away
// from the next edge. Each scenario task makes its own comparisons.
// ---------------------------------------------------------------------------
module tb_mod_mul_stage;

  logic        clk;
  logic        rst_n;
  logic        clear_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] in_1;
  logic [15:0] in_2;
  logic [15:0] q_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] out_1;
  logic [31:0] out_2;
  logic        range_err_o;
  logic [15:0] op_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  mod_mul_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .in_1        (in_1),
    .in_2        (in_2),
    .q_i         (q_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .out_1       (out_1),
    .out_2       (out_2),
    .range_err_o (range_err_o),
    .op_cnt_o    (op_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q);
    valid_i = v;
    in_1    = a;
    in_2    = b;
    q_i     = q;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n   = 1'b0;
    clear_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 16'd0, 16'd0, 16'd1);
    #2;
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_o: got %b want 0", valid_o);
    end
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_o: got %b want 1", ready_o);
    end
    n_checks++;
    if (op_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_op_cnt: got %0d want 0", op_cnt_o);
    end
    n_checks++;
    if (range_err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_range_err: got %b want 0", range_err_o);
    end
    step();
    step();
    rst_n = 1'b1;
    #2;
  endtask

  // -------------------------------------------------------------------------
  // q=3329, a=1234, b=2000 -> 2468000. The edge that accepts the pair is the
  // first of two edges; valid_o is up after the second one.
  task automatic test_single();
    drive(1'b1, 16'd1234, 16'd2000, 16'd3329);
    step();                       // accept edge
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL single_early_valid: got %b want 0", valid_o);
    end
    step();                       // second edge
    n_checks++;
    if (valid_o !== 1'b1) begin
      n_fail++; $display("FAIL single_valid: got %b want 1", valid_o);
    end
    n_checks++;
    if (out_1 !== 32'd2468000) begin
      n_fail++; $display("FAIL single_out_1: got %0d want 2468000", out_1);
    end
    n_checks++;
    if (out_2 !== 32'd3329) begin
      n_fail++; $display("FAIL single_out_2: got %0d want 3329", out_2);
    end
    step();
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL single_one_cycle: got %b want 0", valid_o);
    end
    n_checks++;
    if (op_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL single_op_cnt: got %0d want 1", op_cnt_o);
    end
    n_checks++;
    if (range_err_o !== 1'b0) begin
      n_fail++; $display("FAIL single_range_err: got %b want 0", range_err_o);
    end
  endtask

  // -------------------------------------------------------------------------
  // 65535*65535 = 0xFFFE0001; operands equal to q set the sticky flag.
  task automatic test_max();
    drive(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    step();
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    step();
    n_checks++;
    if (out_1 !== 32'hFFFE0001 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL max_out_1: got %h v=%b want fffe0001 v=1", out_1, valid_o);
    end
    n_checks++;
    if (out_2 !== 32'h0000FFFF) begin
      n_fail++; $display("FAIL max_out_2: got %h want 0000ffff", out_2);
    end
    n_checks++;
    if (range_err_o !== 1'b1) begin
      n_fail++; $display("FAIL max_range_err: got %b want 1", range_err_o);
    end
    // An in-range pair afterwards must not clear the flag.
    drive(1'b1, 16'd5, 16'd6, 16'd7);
    step();
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    step();
    step();
    n_checks++;
    if (range_err_o !== 1'b1) begin
      n_fail++; $display("FAIL max_sticky: got %b want 1", range_err_o);
    end
    n_checks++;
    if (op_cnt_o !== 16'd3) begin
      n_fail++; $display("FAIL max_op_cnt: got %0d want 3", op_cnt_o);
    end
    // q == 0 flags even zero operands; flush afterwards.
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    n_checks++;
    if (range_err_o !== 1'b0 || op_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL max_clear: err=%b cnt=%0d want 0 0", range_err_o, op_cnt_o);
    end
    drive(1'b1, 16'd0, 16'd0, 16'd0);
    step();
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    n_checks++;
    if (range_err_o !== 1'b1) begin
      n_fail++; $display("FAIL q_zero_err: got %b want 1", range_err_o);
    end
    step();
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Eight back-to-back pairs: a=i+1, b=i+10, q=1000 -> product (i+1)*(i+10).
  task automatic test_stream();
    int got;
    logic [31:0] exp_p [8];
    got = 0;
    for (int i = 0; i < 8; i++) exp_p[i] = 32'((i + 1) * (i + 10));
    ready_i = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) drive(1'b1, 16'(cyc + 1), 16'(cyc + 10), 16'd1000);
      else         drive(1'b0, 16'd0, 16'd0, 16'd0);
      #1;
      n_checks++;
      if (ready_o !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready_o cyc%0d: got %b want 1", cyc, ready_o);
      end
      step();
      n_checks++;
      if (valid_o !== (cyc >= 1 && cyc <= 8)) begin
        n_fail++; $display("FAIL stream_valid cyc%0d: got %b", cyc, valid_o);
      end
      if (valid_o === 1'b1 && got < 8) begin
        n_checks++;
        if (out_1 !== exp_p[got]) begin
          n_fail++; $display("FAIL stream_out_1 #%0d: got %0d want %0d", got, out_1, exp_p[got]);
        end
        got++;
      end
    end
    n_checks++;
    if (got !== 8) begin
      n_fail++; $display("FAIL stream_count: got %0d want 8", got);
    end
    n_checks++;
    if (op_cnt_o !== 16'd8) begin
      n_fail++; $display("FAIL stream_op_cnt: got %0d want 8", op_cnt_o);
    end
  endtask

  // -------------------------------------------------------------------------
  // Pairs 3*4=12, 5*6=30, 7*8=56 fed with ready_i low.
  task automatic test_backpressure();
    ready_i = 1'b0;
    drive(1'b1, 16'd3, 16'd4, 16'd100);
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_0: got %b want 1", ready_o);
    end
    step();
    drive(1'b1, 16'd5, 16'd6, 16'd100);
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_1: got %b want 1", ready_o);
    end
    step();
    drive(1'b1, 16'd7, 16'd8, 16'd100);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (ready_o !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready_full %0d: got %b want 0", k, ready_o);
      end
      n_checks++;
      if (valid_o !== 1'b1 || out_1 !== 32'd12 || out_2 !== 32'd100) begin
        n_fail++; $display("FAIL bp_hold %0d: v=%b out_1=%0d out_2=%0d want 1 12 100",
                           k, valid_o, out_1, out_2);
      end
      step();
    end
    ready_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_release: got %b want 1", ready_o);
    end
    step();                       // 12 delivered, 7*8 accepted
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    n_checks++;
    if (valid_o !== 1'b1 || out_1 !== 32'd30) begin
      n_fail++; $display("FAIL bp_second: v=%b out_1=%0d want 1 30", valid_o, out_1);
    end
    step();
    n_checks++;
    if (valid_o !== 1'b1 || out_1 !== 32'd56) begin
      n_fail++; $display("FAIL bp_third: v=%b out_1=%0d want 1 56", valid_o, out_1);
    end
    step();
    n_checks++;
    if (valid_o !== 1'b0 || op_cnt_o !== 16'd11) begin
      n_fail++; $display("FAIL bp_done: v=%b cnt=%0d want 0 11", valid_o, op_cnt_o);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_clear();
    ready_i = 1'b0;
    drive(1'b1, 16'd2, 16'd3, 16'd50);
    step();
    drive(1'b1, 16'd4, 16'd5, 16'd50);
    step();
    // Input offered in the clear cycle is dropped.
    clear_i = 1'b1;
    drive(1'b1, 16'd9, 16'd9, 16'd5);
    step();
    clear_i = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    n_checks++;
    if (valid_o !== 1'b0 || op_cnt_o !== 16'd0 || range_err_o !== 1'b0) begin
      n_fail++; $display("FAIL clear_state: v=%b cnt=%0d err=%b want 0 0 0",
                         valid_o, op_cnt_o, range_err_o);
    end
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (valid_o !== 1'b0) begin
        n_fail++; $display("FAIL clear_no_ghost %0d: got %b want 0", k, valid_o);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // 65536 deliveries bring the counter back to zero.
  task automatic test_wrap();
    bit dropped;
    dropped = 1'b0;
    ready_i = 1'b1;
    drive(1'b1, 16'd1, 16'd1, 16'd2);
    for (int k = 0; k < 65536; k++) begin
      if (ready_o !== 1'b1) dropped = 1'b1;
      step();
    end
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    n_checks++;
    if (dropped) begin
      n_fail++; $display("FAIL wrap_ready_o: ready_o dropped during stream");
    end
    step();                       // 65535th delivery
    n_checks++;
    if (op_cnt_o !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_ffff: got %h want ffff", op_cnt_o);
    end
    step();                       // 65536th delivery
    n_checks++;
    if (op_cnt_o !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero: got %h want 0000", op_cnt_o);
    end
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL wrap_drained: got %b want 0", valid_o);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_async_reset();
    ready_i = 1'b1;
    drive(1'b1, 16'd20, 16'd3, 16'd10);   // 20 >= 10 sets the flag
    step();
    drive(1'b1, 16'd2, 16'd3, 16'd10);
    step();
    step();
    // valid_o high with a pair behind it, counter at 1, flag set.
    n_checks++;
    if (valid_o !== 1'b1 || op_cnt_o !== 16'd1 || range_err_o !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: v=%b cnt=%0d err=%b want 1 1 1",
                         valid_o, op_cnt_o, range_err_o);
    end
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    #2;
    rst_n = 1'b0;                        // between edges
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || op_cnt_o !== 16'd0 || range_err_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++; $display("FAIL arst_immediate: v=%b cnt=%0d err=%b rdy=%b want 0 0 0 1",
                         valid_o, op_cnt_o, range_err_o, ready_o);
    end
    step();
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (valid_o !== 1'b0) begin
        n_fail++; $display("FAIL arst_stale %0d: got %b want 0", k, valid_o);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    clear_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 16'd0, 16'd0, 16'd1);
    test_reset();
    test_single();
    test_max();
    test_stream();
    test_backpressure();
    test_clear();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
